// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// codes, FSM state encoding, step mode and the divide-by-zero quotient.
package muldiv_pkg;

  // Operation codes presented on the op input
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Selects what one iteration of the datapath does
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Widest operand supported; the quotient constant is sliced to WIDTH
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a division by zero (all ones)
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // True for the two's-complement flavours of multiply and divide
  function automatic logic isSignedOp(input logic [2:0] opCode);
    return (opCode == OP_MULT) || (opCode == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// The accumulator is 2*WIDTH+1 bits wide: the upper WIDTH+1 bits hold the
// partial product (multiply) or partial remainder (divide), the lower WIDTH
// bits hold the multiplier being consumed or the dividend/quotient.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  step_mode_e       mode_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;

  // Shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    upper   = acc_i[2*WIDTH:WIDTH];
    sum     = upper + {1'b0, operand_i};
    shifted = {acc_i[2*WIDTH-1:0], 1'b0};
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, operand_i};
    acc_o   = acc_i;
    if (mode_i == STEP_MUL) begin
      if (acc_i[0]) begin
        acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, upper, acc_i[WIDTH-1:1]};
      end
    end else begin
      if (diff[WIDTH]) begin
        acc_o = shifted;
      end else begin
        acc_o = {diff, shifted[WIDTH-1:1], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI and LO registers.
// Signed operations run on magnitudes; signs are restored in the FIX cycle.
// A result lands WIDTH+1 edges after start is sampled, with a one-cycle done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  step_mode_e         mode_q, mode_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   rsRaw_q, rsRaw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH:0]   stepAcc;

  logic               opSigned;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] productFix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .operand_i(operand_q),
    .mode_i   (mode_q),
    .acc_o    (stepAcc)
  );

  // Operand magnitudes and sign flags for a newly issued operation
  always_comb begin
    opSigned = isSignedOp(op);
    negA     = opSigned & rs_val[WIDTH-1];
    negB     = opSigned & rt_val[WIDTH-1];
    magA     = negA ? -rs_val : rs_val;
    magB     = negB ? -rt_val : rt_val;
  end

  // Sign-corrected results taken from the finished accumulator
  always_comb begin
    product    = acc_q[2*WIDTH-1:0];
    productFix = negRes_q ? -product : product;
    quot       = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];
    quotFix    = negRes_q ? -quot : quot;
    remFix     = negRem_q ? -rem : rem;
  end

  // Controller: issue in IDLE, iterate in RUN, write HI/LO in FIX
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    mode_d    = mode_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    rsRaw_d   = rsRaw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d     = {{(WIDTH+1){1'b0}}, magB};
              operand_d = magA;
              mode_d    = STEP_MUL;
              negRes_d  = negA ^ negB;
              negRem_d  = 1'b0;
              divZero_d = 1'b0;
              count_d   = '0;
              state_d   = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = {{(WIDTH+1){1'b0}}, magA};
              operand_d = magB;
              mode_d    = STEP_DIV;
              negRes_d  = negA ^ negB;
              negRem_d  = negA;
              divZero_d = (rt_val == '0);
              rsRaw_d   = rs_val;
              count_d   = '0;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = stepAcc;
        if (count_q == LAST_STEP) begin
          count_d = '0;
          state_d = ST_FIX;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ST_FIX: begin
        if (mode_q == STEP_MUL) begin
          hi_d = productFix[2*WIDTH-1:WIDTH];
          lo_d = productFix[WIDTH-1:0];
        end else if (divZero_q) begin
          lo_d = DIV_ZERO_QUOTIENT[WIDTH-1:0];
          hi_d = rsRaw_q;
        end else begin
          lo_d = quotFix;
          hi_d = remFix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation without touching HI/LO later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      mode_q    <= STEP_MUL;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      rsRaw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      mode_q    <= mode_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      rsRaw_q   <= rsRaw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences (MTHI/MTLO, ignored starts, reset abort) and random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int LATENCY = WIDTH + 1;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [2:0]  vop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[11];

  muldiv_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference results from MIPS rules using plain integer arithmetic
  function automatic logic [63:0] refModel(input logic [2:0] rop,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sp;
    logic [63:0] full;
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    full = '0;
    case (rop)
      OP_MULT: begin
        sp   = longint'($signed(a)) * longint'($signed(b));
        full = sp;
      end
      OP_MULTU: full = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'd0) full = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) full = {32'd0, 32'h80000000};
        else begin
          sa   = $signed(a);
          sb   = $signed(b);
          q    = sa / sb;
          r    = sa % sb;
          full = {r, q};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) full = {a, 32'hFFFFFFFF};
        else full = {a % b, a / b};
      end
      default: full = '0;
    endcase
    return full;
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Present one request for exactly one sampling edge
  task automatic applyStimulus(input logic [2:0] sop, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clock);
    start  = 1'b1;
    op     = sop;
    rs_val = a;
    rt_val = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Issue a multi-cycle op and check latency, busy length, HI/LO hold and result
  task automatic runOp(input string name, input logic [2:0] sop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] hiBefore;
    logic [31:0] loBefore;
    int          cycles;
    int          busyCycles;
    logic        holdBad;
    hiBefore   = hi;
    loBefore   = lo;
    cycles     = 0;
    busyCycles = 0;
    holdBad    = 1'b0;
    applyStimulus(sop, a, b);
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busyCycles++;
      if (hi !== hiBefore || lo !== loBefore) holdBad = 1'b1;
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput({name, " latency"}, 64'(cycles), 64'(LATENCY));
    checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'(LATENCY));
    checkOutput({name, " hi/lo hold"}, 64'(holdBad), 64'd0);
    checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({name, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({name, " lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    int          cycles;
    logic        sawAaaa;
    logic [31:0] hiSave;
    logic [31:0] loSave;
    logic [63:0] exp;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_MULTU, 32'd3,        32'd4,        32'd0,        32'd12};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
    vecs[10] = '{OP_DIV,   32'h80000000, 32'd2,        32'd0,        32'hC0000000};

    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table, issued back-to-back in each done cycle
    for (int i = 0; i < 11; i++) begin
      if (i > 0) checkOutput($sformatf("vec%0d done before b2b start", i), 64'(done), 64'd1);
      runOp($sformatf("vec%0d", i), vecs[i].vop, vecs[i].a, vecs[i].b,
            vecs[i].expHi, vecs[i].expLo);
    end
    @(posedge clock);
    #1;
    checkOutput("done one cycle", 64'(done), 64'd0);
    checkOutput("idle busy", 64'(busy), 64'd0);

    // MTHI / MTLO take effect on the sampling edge without going busy
    applyStimulus(OP_MTHI, 32'h12345678, 32'd0);
    checkOutput("mthi hi", 64'(hi), 64'h12345678);
    checkOutput("mthi busy", 64'(busy), 64'd0);
    checkOutput("mthi done", 64'(done), 64'd0);
    applyStimulus(OP_MTLO, 32'h0BADF00D, 32'd0);
    checkOutput("mtlo lo", 64'(lo), 64'h0BADF00D);
    checkOutput("mtlo hi kept", 64'(hi), 64'h12345678);
    checkOutput("mtlo busy", 64'(busy), 64'd0);

    // Undefined op is a no-op
    hiSave = hi;
    loSave = lo;
    applyStimulus(3'd6, 32'hDEADBEEF, 32'd1);
    @(posedge clock);
    #1;
    checkOutput("undef op busy", 64'(busy), 64'd0);
    checkOutput("undef op hi", 64'(hi), 64'(hiSave));
    checkOutput("undef op lo", 64'(lo), 64'(loSave));

    // Requests while busy are dropped, including MTLO
    applyStimulus(OP_DIVU, 32'd50, 32'd7);
    cycles  = 0;
    sawAaaa = 1'b0;
    while (done !== 1'b1 && cycles < 100) begin
      if (cycles == 3) begin
        start  = 1'b1;
        op     = OP_MTLO;
        rs_val = 32'h0000AAAA;
      end else if (cycles == 4) begin
        op     = OP_MULT;
        rs_val = 32'd3;
        rt_val = 32'd3;
      end else if (cycles == 5) begin
        start = 1'b0;
      end
      if (lo == 32'h0000AAAA) sawAaaa = 1'b1;
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput("ignore latency", 64'(cycles), 64'(LATENCY));
    checkOutput("ignore mtlo seen", 64'(sawAaaa), 64'd0);
    checkOutput("ignore divu lo", 64'(lo), 64'd7);
    checkOutput("ignore divu hi", 64'(hi), 64'd1);
    @(posedge clock);
    #1;
    checkOutput("ignore no queued op", 64'(busy), 64'd0);

    // Reset in the middle of a multiply aborts it immediately
    applyStimulus(OP_MULT, 32'h00001234, 32'h00005678);
    repeat (10) @(posedge clock);
    @(negedge clock);
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    runOp("post-reset divu", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

    // Random operations against the reference model
    for (int n = 0; n < 25; n++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      exp = refModel(rop, ra, rb);
      runOp($sformatf("rand%0d op%0d 0x%0h,0x%0h", n, rop, ra, rb), rop, ra, rb,
            exp[63:32], exp[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
